// File: rtl/add_later.sv
// Running-sum reconstructor: rebuilds unsigned 4-bit samples from a stream of
// signed 5-bit differences, framed by absolute start samples; outputs registered.
module add_later #(
    parameter int FRAME_LEN = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inValid,
    input  logic       inStart,
    input  logic [4:0] diffIn,
    output logic [3:0] dataOut,
    output logic       outValid,
    output logic       frameEnd,
    output logic       rangeErr
);

    typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;

    state_t      state, next_state;
    logic [3:0]  count, prev;
    logic [3:0]  count_nxt, prev_nxt, data_nxt;
    logic        ov_nxt, fe_nxt, re_nxt;
    logic signed [5:0] sum;
    logic        sum_ok, start_ok, last;

    // prev is an unsigned sample, so it is zero-extended; only diffIn carries a sign
    assign sum      = $signed({2'b00, prev}) + $signed({diffIn[4], diffIn});
    assign sum_ok   = ~sum[5] & ~sum[4];
    assign start_ok = ~diffIn[4];
    assign last     = (count + 4'd1) == 4'(FRAME_LEN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            prev     <= '0;
            dataOut  <= '0;
            outValid <= 1'b0;
            frameEnd <= 1'b0;
            rangeErr <= 1'b0;
        end else begin
            state    <= next_state;
            count    <= count_nxt;
            prev     <= prev_nxt;
            dataOut  <= data_nxt;
            outValid <= ov_nxt;
            frameEnd <= fe_nxt;
            rangeErr <= re_nxt;
        end
    end

    // inStart wins over difference processing in every state
    always_comb begin
        next_state = state;
        if (inValid) begin
            if (inStart)
                next_state = start_ok ? RUN : ERR;
            else if (state == RUN)
                next_state = !sum_ok ? ERR : (last ? IDLE : RUN);
        end
    end

    always_comb begin
        data_nxt  = dataOut;
        prev_nxt  = prev;
        count_nxt = count;
        ov_nxt    = 1'b0;
        fe_nxt    = 1'b0;
        re_nxt    = 1'b0;
        if (inValid) begin
            if (inStart) begin
                if (start_ok) begin
                    data_nxt  = diffIn[3:0];
                    prev_nxt  = diffIn[3:0];
                    count_nxt = 4'd1;
                    ov_nxt    = 1'b1;
                end else begin
                    count_nxt = '0;
                    re_nxt    = 1'b1;
                end
            end else if (state == RUN) begin
                if (sum_ok) begin
                    data_nxt  = sum[3:0];
                    prev_nxt  = sum[3:0];
                    count_nxt = last ? 4'd0 : count + 4'd1;
                    ov_nxt    = 1'b1;
                    fe_nxt    = last;
                end else begin
                    count_nxt = '0;
                    re_nxt    = 1'b1;
                end
            end
        end
    end

endmodule
